// File: rtl/sva_sched_pkg.sv
// Shared types for the SVA evaluation scheduler: checker thread info layout
// and scheduler FSM states.
package sva_sched_pkg;

  localparam int TIMER_WIDTH = 31;

  typedef enum logic [1:0] {
    FSM_INACTIVE,
    FSM_ANTE,
    FSM_CONS,
    FSM_LAZY
  } sva_fsm_t;

  typedef struct packed {
    logic                   active;
    logic [TIMER_WIDTH-1:0] start_period;
    sva_fsm_t               fsm_cur;
  } sva_info_t;

  localparam int SVA_INFO_W = $bits(sva_info_t);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    WAIT,
    DONE
  } sched_state_t;

endpackage

// File: rtl/sva_eval_sched_if.sv
// Requester and engine handshake bundle. The master modport is the
// scheduler side; the slave modport is the requesters plus the engine.
interface sva_eval_sched_if
  import sva_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int INFO_W  = SVA_INFO_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*INFO_W-1:0] req_info;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      eval_valid;
  logic [ID_W-1:0]           eval_id;
  logic [INFO_W-1:0]         eval_info;

  logic                      eval_rsp_valid;
  logic [INFO_W-1:0]         eval_rsp_info;
  logic                      eval_rsp_succ;
  logic                      eval_rsp_fail;
  logic                      eval_rsp_lazy;

  logic [NUM_REQ-1:0]        rsp_valid;
  logic [INFO_W-1:0]         rsp_info;

  modport master (
    input  req_valid, req_info, req_done,
    input  eval_rsp_valid, eval_rsp_info, eval_rsp_succ, eval_rsp_fail, eval_rsp_lazy,
    output req_ready, eval_valid, eval_id, eval_info, rsp_valid, rsp_info
  );

  modport slave (
    output req_valid, req_info, req_done,
    output eval_rsp_valid, eval_rsp_info, eval_rsp_succ, eval_rsp_fail, eval_rsp_lazy,
    input  req_ready, eval_valid, eval_id, eval_info, rsp_valid, rsp_info
  );

endinterface

// File: rtl/sva_rr_arbiter.sv
// Combinational round-robin pick: first set mask bit after rr_ptr_i,
// wrapping around.
module sva_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               found_o
);

  always_comb begin
    int idx;
    grant_o    = '0;
    grant_id_o = '0;
    found_o    = 1'b0;
    idx        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr_i) + k) % NUM_REQ;
      if (!found_o && mask_i[idx]) begin
        found_o      = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sva_eval_sched.sv
// Shares one SVA next-state engine between NUM_REQ checker queues, one
// thread at a time per gclk epoch, and keeps saturating verdict totals.
//
// state | meaning
// IDLE  | waiting for a gclk edge to open an epoch
// ARB   | drop finished queues, grant the next eligible thread
// WAIT  | engine request outstanding, waiting for its result
// DONE  | epoch_done pulse, back to IDLE
module sva_eval_sched
  import sva_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int INFO_W  = SVA_INFO_W,
  parameter int CNT_W   = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               gclk_posedge_flag,
  input  logic [NUM_REQ-1:0] chk_en,
  sva_eval_sched_if.master   bus,
  output logic [CNT_W-1:0]   succ_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [CNT_W-1:0]   lazy_cnt,
  output logic               epoch_busy,
  output logic               epoch_done,
  output logic               overrun,
  output logic               overrun_sticky
);

  sched_state_t        state_q, state_d;
  logic [NUM_REQ-1:0]  pending_q, pending_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                eval_valid_q, eval_valid_d;
  logic [ID_W-1:0]     eval_id_q, eval_id_d;
  logic [INFO_W-1:0]   eval_info_q, eval_info_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [INFO_W-1:0]   rsp_info_q, rsp_info_d;
  logic [CNT_W-1:0]    succ_q, succ_d, fail_q, fail_d, lazy_q, lazy_d;
  logic                epoch_done_q, epoch_done_d;
  logic                overrun_q, overrun_d;
  logic                sticky_q, sticky_d;

  logic [NUM_REQ-1:0]  pend_live, elig, gnt_oh, req_ready_c;
  logic [ID_W-1:0]     gnt_id;
  logic                found;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && !(&v)) ? v + 1'b1 : v;
  endfunction

  // A queue leaves the epoch once it reports done with nothing left to present.
  assign pend_live = pending_q & ~(bus.req_done & ~bus.req_valid);
  assign elig      = pend_live & bus.req_valid;

  sva_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .mask_i     (elig),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (gnt_oh),
    .grant_id_o (gnt_id),
    .found_o    (found)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    rr_ptr_d     = rr_ptr_q;
    eval_valid_d = 1'b0;
    eval_id_d    = eval_id_q;
    eval_info_d  = eval_info_q;
    rsp_valid_d  = '0;
    rsp_info_d   = rsp_info_q;
    succ_d       = succ_q;
    fail_d       = fail_q;
    lazy_d       = lazy_q;
    epoch_done_d = 1'b0;
    overrun_d    = gclk_posedge_flag && (state_q != IDLE);
    sticky_d     = sticky_q | overrun_d;
    req_ready_c  = '0;

    case (state_q)
      IDLE: begin
        if (gclk_posedge_flag) begin
          pending_d = chk_en;
          state_d   = ARB;
        end
      end
      ARB: begin
        pending_d = pend_live;
        if (pend_live == '0) begin
          state_d      = DONE;
          epoch_done_d = 1'b1;
        end else if (found) begin
          req_ready_c  = gnt_oh;
          eval_valid_d = 1'b1;
          eval_id_d    = gnt_id;
          eval_info_d  = bus.req_info[gnt_id*INFO_W +: INFO_W];
          rr_ptr_d     = gnt_id;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (bus.eval_rsp_valid) begin
          rsp_valid_d[eval_id_q] = 1'b1;
          rsp_info_d             = bus.eval_rsp_info;
          succ_d                 = sat_inc(succ_q, bus.eval_rsp_succ);
          fail_d                 = sat_inc(fail_q, bus.eval_rsp_fail);
          lazy_d                 = sat_inc(lazy_q, bus.eval_rsp_lazy);
          state_d                = ARB;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      eval_valid_q <= 1'b0;
      eval_id_q    <= '0;
      eval_info_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_info_q   <= '0;
      succ_q       <= '0;
      fail_q       <= '0;
      lazy_q       <= '0;
      epoch_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      eval_valid_q <= eval_valid_d;
      eval_id_q    <= eval_id_d;
      eval_info_q  <= eval_info_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_info_q   <= rsp_info_d;
      succ_q       <= succ_d;
      fail_q       <= fail_d;
      lazy_q       <= lazy_d;
      epoch_done_q <= epoch_done_d;
      overrun_q    <= overrun_d;
      sticky_q     <= sticky_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.eval_valid = eval_valid_q;
  assign bus.eval_id    = eval_id_q;
  assign bus.eval_info  = eval_info_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_info   = rsp_info_q;

  assign succ_cnt       = succ_q;
  assign fail_cnt       = fail_q;
  assign lazy_cnt       = lazy_q;
  assign epoch_busy     = (state_q != IDLE);
  assign epoch_done     = epoch_done_q;
  assign overrun        = overrun_q;
  assign overrun_sticky = sticky_q;

endmodule

// File: tb/tb_sva_eval_sched.sv
// Scoreboard bench for sva_eval_sched: per-queue thread lists, a latency
// programmable engine, and a round-robin reference model of each epoch.
module tb_sva_eval_sched;
  import sva_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int INFO_W  = SVA_INFO_W;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               gclk_posedge_flag = 1'b0;
  logic [NUM_REQ-1:0] chk_en = '0;
  logic [CNT_W-1:0]   succ_cnt, fail_cnt, lazy_cnt;
  logic               epoch_busy, epoch_done, overrun, overrun_sticky;

  sva_eval_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .INFO_W(INFO_W)) bus ();

  sva_eval_sched #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .INFO_W  (INFO_W),
    .CNT_W   (CNT_W)
  ) dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .gclk_posedge_flag (gclk_posedge_flag),
    .chk_en            (chk_en),
    .bus               (bus),
    .succ_cnt          (succ_cnt),
    .fail_cnt          (fail_cnt),
    .lazy_cnt          (lazy_cnt),
    .epoch_busy        (epoch_busy),
    .epoch_done        (epoch_done),
    .overrun           (overrun),
    .overrun_sticky    (overrun_sticky)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [INFO_W-1:0] info;
  } item_t;

  int checks = 0;
  int errors = 0;
  item_t exp_eval[$];
  item_t exp_rsp[$];
  logic [INFO_W-1:0] thr_q[NUM_REQ][$];
  int eval_log[$];
  int done_cnt = 0;
  int ovr_cnt  = 0;
  int eval_cnt = 0;
  int rr_model = NUM_REQ - 1;
  int m_succ = 0, m_fail = 0, m_lazy = 0;
  int eng_lat = 1;
  item_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [INFO_W-1:0] eng_next(input logic [INFO_W-1:0] v);
    return {v[INFO_W-2:0], ~v[INFO_W-1]};
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // Requesters and engine: the only process driving the slave side of the bus.
  initial begin
    logic [NUM_REQ-1:0]        rdy_s;
    logic [INFO_W-1:0]         eng_info;
    logic [NUM_REQ*INFO_W-1:0] info_v;
    int                        eng_cnt;
    eng_cnt  = 0;
    eng_info = '0;
    bus.req_valid = '0; bus.req_info = '0; bus.req_done = '1;
    bus.eval_rsp_valid = 1'b0; bus.eval_rsp_info = '0;
    bus.eval_rsp_succ = 1'b0; bus.eval_rsp_fail = 1'b0; bus.eval_rsp_lazy = 1'b0;
    forever begin
      @(negedge sys_clk);
      rdy_s = bus.req_ready & bus.req_valid;
      if (bus.eval_valid) begin
        eng_info = bus.eval_info;
        eng_cnt  = (eng_lat == 0) ? int'($urandom_range(1, 4)) : eng_lat;
      end
      @(posedge sys_clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (rdy_s[i] && thr_q[i].size() > 0) void'(thr_q[i].pop_front());
      bus.eval_rsp_valid = 1'b0;
      bus.eval_rsp_succ  = 1'b0;
      bus.eval_rsp_fail  = 1'b0;
      bus.eval_rsp_lazy  = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          bus.eval_rsp_valid = 1'b1;
          bus.eval_rsp_info  = eng_next(eng_info);
          bus.eval_rsp_succ  = eng_info[0];
          bus.eval_rsp_fail  = eng_info[1];
          bus.eval_rsp_lazy  = eng_info[2];
        end
      end
      info_v = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_valid[i] = (thr_q[i].size() > 0);
        bus.req_done[i]  = (thr_q[i].size() == 0);
        if (thr_q[i].size() > 0) info_v[i*INFO_W +: INFO_W] = thr_q[i][0];
      end
      bus.req_info = info_v;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an issue or a result.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (bus.eval_valid) begin
        eval_cnt++;
        eval_log.push_back(int'(bus.eval_id));
        if (exp_eval.size() == 0) check("eval_unexpected", 64'(bus.eval_valid), 64'd0);
        else begin
          mon_e = exp_eval.pop_front();
          check("eval_id", 64'(bus.eval_id), 64'(mon_e.id));
          check("eval_info", 64'(bus.eval_info), 64'(mon_e.info));
        end
      end
      if (bus.rsp_valid != '0) begin
        if (exp_rsp.size() == 0) check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
        else begin
          mon_e = exp_rsp.pop_front();
          check("rsp_valid", 64'(bus.rsp_valid), 64'd1 << mon_e.id);
          check("rsp_info", 64'(bus.rsp_info), 64'(mon_e.info));
        end
      end
      if (epoch_done) done_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1'b1;
    gclk_posedge_flag = 1'b0;
    exp_eval.delete();
    exp_rsp.delete();
    for (int i = 0; i < NUM_REQ; i++) thr_q[i].delete();
    rr_model = NUM_REQ - 1;
    m_succ = 0; m_fail = 0; m_lazy = 0;
    tick(n);
    sys_rst = 1'b0;
  endtask

  task automatic load(input int q, input int n, input logic [2:0] flags, input bit rnd_flags);
    logic [INFO_W-1:0] v;
    for (int k = 0; k < n; k++) begin
      v = INFO_W'({$urandom, $urandom});
      if (!rnd_flags) v[2:0] = flags;
      thr_q[q].push_back(v);
    end
  endtask

  // Reference: serve the next enabled queue with work after the last one served.
  task automatic plan_epoch(input logic [NUM_REQ-1:0] en);
    int rem[NUM_REQ];
    int pos[NUM_REQ];
    int pick;
    logic [INFO_W-1:0] v;
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = en[i] ? thr_q[i].size() : 0;
      pos[i] = 0;
    end
    forever begin
      pick = -1;
      for (int k = 1; k <= NUM_REQ; k++)
        if (pick < 0 && rem[(rr_model + k) % NUM_REQ] > 0) pick = (rr_model + k) % NUM_REQ;
      if (pick < 0) break;
      v = thr_q[pick][pos[pick]];
      exp_eval.push_back({ID_W'(pick), v});
      exp_rsp.push_back({ID_W'(pick), eng_next(v)});
      m_succ = sat(m_succ + int'(v[0]));
      m_fail = sat(m_fail + int'(v[1]));
      m_lazy = sat(m_lazy + int'(v[2]));
      pos[pick]++;
      rem[pick]--;
      rr_model = pick;
    end
  endtask

  task automatic pulse_flag();
    gclk_posedge_flag = 1'b1;
    tick();
    gclk_posedge_flag = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < bound) begin
      tick();
      n++;
    end
    check("epoch_done_seen", 64'(done_cnt != start), 64'd1);
  endtask

  task automatic wait_eval(input int bound);
    int start = eval_cnt;
    int n = 0;
    while (eval_cnt == start && n < bound) begin
      tick();
      n++;
    end
    check("eval_seen", 64'(eval_cnt != start), 64'd1);
  endtask

  task automatic run_epoch(input logic [NUM_REQ-1:0] en, input int lat);
    eng_lat = lat;
    chk_en  = en;
    plan_epoch(en);
    tick(2);
    pulse_flag();
    wait_done(800);
    check("succ_cnt", 64'(succ_cnt), 64'(m_succ));
    check("fail_cnt", 64'(fail_cnt), 64'(m_fail));
    check("lazy_cnt", 64'(lazy_cnt), 64'(m_lazy));
    check("eval_missing", 64'(exp_eval.size()), 64'd0);
    check("rsp_missing", 64'(exp_rsp.size()), 64'd0);
    tick();
    check("busy_after", 64'(epoch_busy), 64'd0);
  endtask

  initial begin
    int ev0, d0, o0;
    bit saw_rsp;
    int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    do_reset(3);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_eval_valid", 64'(bus.eval_valid), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_cnts", 64'({succ_cnt, fail_cnt, lazy_cnt}), 64'd0);
    check("rst_flags", 64'({epoch_busy, epoch_done, overrun, overrun_sticky}), 64'd0);

    // single queue, two threads, one success verdict
    load(0, 1, 3'b001, 1'b0);
    load(0, 1, 3'b000, 1'b0);
    eval_log.delete();
    run_epoch(4'b0001, 1);
    check("single_succ", 64'(succ_cnt), 64'd1);
    check("single_evals", 64'(eval_log.size()), 64'd2);

    // round robin across all queues, then a fresh epoch restarts at queue 0
    do_reset(2);
    for (int i = 0; i < NUM_REQ; i++) load(i, 2, 3'b000, 1'b1);
    eval_log.delete();
    run_epoch(4'b1111, 1);
    check("rr_len", 64'(eval_log.size()), 64'd8);
    if (eval_log.size() == 8)
      for (int k = 0; k < 8; k++) check("rr_seq", 64'(eval_log[k]), 64'(exp_seq[k]));
    for (int i = 0; i < NUM_REQ; i++) load(i, 1, 3'b000, 1'b1);
    eval_log.delete();
    run_epoch(4'b1111, 1);
    check("rr_restart", 64'((eval_log.size() > 0) ? eval_log[0] : -1), 64'd0);

    // empty epoch: done exactly two cycles after the flag
    chk_en = '0;
    tick(2);
    ev0 = eval_cnt;
    pulse_flag();
    check("empty_t1_done", 64'(epoch_done), 64'd0);
    check("empty_t1_busy", 64'(epoch_busy), 64'd1);
    tick();
    check("empty_t2_done", 64'(epoch_done), 64'd1);
    tick();
    check("empty_t3", 64'({epoch_done, epoch_busy}), 64'd0);
    check("empty_no_eval", 64'(eval_cnt - ev0), 64'd0);

    // overrun during a long engine wait
    check("sticky_pre", 64'(overrun_sticky), 64'd0);
    load(0, 1, 3'b000, 1'b1);
    eng_lat = 20;
    chk_en  = 4'b0001;
    plan_epoch(4'b0001);
    tick(2);
    d0 = done_cnt;
    o0 = ovr_cnt;
    pulse_flag();
    wait_eval(10);
    tick(2);
    pulse_flag();
    check("overrun_pulse", 64'(overrun), 64'd1);
    check("overrun_sticky", 64'(overrun_sticky), 64'd1);
    tick();
    check("overrun_clear", 64'(overrun), 64'd0);
    wait_done(60);
    tick(10);
    check("overrun_one_done", 64'(done_cnt - d0), 64'd1);
    check("overrun_count", 64'(ovr_cnt - o0), 64'd1);
    check("overrun_idle", 64'({epoch_busy, overrun_sticky}), 64'b01);

    // fail counter saturates at 3 and holds
    do_reset(1);
    load(0, 5, 3'b010, 1'b0);
    run_epoch(4'b0001, 1);
    check("sat_fail", 64'(fail_cnt), 64'd3);
    tick(3);
    check("sat_hold", 64'(fail_cnt), 64'd3);

    // randomized epochs against the reference
    for (int e = 0; e < 15; e++) begin
      logic [NUM_REQ-1:0] en;
      if ($urandom_range(0, 2) == 0) do_reset(1);
      en = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) load(i, $urandom_range(0, 3), 3'b000, 1'b1);
      run_epoch(en, 0);
    end

    // reset while waiting on the engine; the late result must be ignored
    do_reset(1);
    load(0, 1, 3'b111, 1'b0);
    eng_lat = 20;
    chk_en  = 4'b0001;
    plan_epoch(4'b0001);
    tick(2);
    pulse_flag();
    wait_eval(10);
    tick(2);
    do_reset(1);
    saw_rsp = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      saw_rsp |= (bus.rsp_valid != '0);
    end
    check("rstw_no_rsp", 64'(saw_rsp), 64'd0);
    check("rstw_cnts", 64'({succ_cnt, fail_cnt, lazy_cnt}), 64'd0);
    check("rstw_idle", 64'({epoch_busy, bus.eval_valid}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/sva_eval_sched.md
Name: sva_eval_sched

Overview:
- Round-robin scheduler that shares one SVA next-state evaluation engine (the get-next-state datapath of a generated checker) between NUM_REQ checker thread queues.
- Each gclk rising edge, already detected on sys_clk, opens an epoch. Within an epoch the block grants queues one thread at a time and routes each engine result back to its owner.
- It also keeps global succ/fail/lazy_succ statistics and flags epochs that overrun the next gclk edge.

Parameters:
NUM_REQ, 4, number of checker queues (≥2)
ID_W, $clog2(NUM_REQ), requester id width
INFO_W, 34, packed sva_info_t width (active + start_period + fsm_cur)
CNT_W, 16, statistic counter width (saturating)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
gclk_posedge_flag  in  1  one-cycle pulse, epoch start
chk_en  in  NUM_REQ  queue enable, sampled at epoch start
req_valid  in  NUM_REQ  queue i presents a thread
req_info  in  NUM_REQ*INFO_W  thread info, slice i
req_done  in  NUM_REQ  queue i has no further threads this epoch (level)
req_ready  out  NUM_REQ  one-hot grant, thread consumed
eval_valid  out  1  one-cycle issue pulse to engine
eval_id  out  ID_W  granted queue
eval_info  out  INFO_W  granted thread
eval_rsp_valid  in  1  engine result pulse
eval_rsp_info  in  INFO_W  next sva_info
eval_rsp_succ / eval_rsp_fail / eval_rsp_lazy  in  1 each  engine verdict flags
rsp_valid  out  NUM_REQ  one-hot result return
rsp_info  out  INFO_W  result info
succ_cnt / fail_cnt / lazy_cnt  out  CNT_W each  saturating totals
epoch_busy  out  1  epoch in progress
epoch_done  out  1  one-cycle pulse at epoch end
overrun  out  1  one-cycle pulse, epoch start dropped
overrun_sticky  out  1  set by any overrun

Behaviour:
- Reset, synchronous on sys_clk while sys_rst=1:
  - All outputs 0, all counters 0.
  - pending=0, state IDLE, rr_ptr=NUM_REQ-1 so queue 0 wins first.
  - Reset mid-epoch abandons the epoch; an outstanding engine response is ignored.
- IDLE: on gclk_posedge_flag, latch pending=chk_en and go to ARB next cycle.
- ARB:
  - Clear every pending bit i with req_done[i]=1 and req_valid[i]=0.
  - If pending is empty after that clear, go to DONE.
  - Otherwise pick the first i with pending[i]&req_valid[i], searching from rr_ptr+1 with wrap-around.
  - Drive req_ready[i]=1 combinationally in this same cycle. The requester pops its thread on valid&ready.
  - Register eval_valid=1, eval_id=i, eval_info=slice i; set rr_ptr=i; go to WAIT.
  - If no queue is eligible, stay in ARB (stall).
- WAIT:
  - eval_valid is high only in the first WAIT cycle.
  - Wait for eval_rsp_valid, earliest one cycle after eval_valid. There is no timeout.
  - One cycle after the response:
    - rsp_valid[eval_id]=1 and rsp_info=eval_rsp_info.
    - Each counter increments by its flag, saturating at 2^CNT_W-1.
    - State returns to ARB.
  - eval_rsp_valid outside WAIT is ignored.
- DONE: epoch_done=1 for one cycle, then IDLE.
- epoch_busy=1 in ARB/WAIT/DONE.
- chk_en=0 everywhere: flag at T gives ARB at T+1, DONE at T+2, epoch_done=1 at T+2.
- gclk_posedge_flag while not in IDLE:
  - overrun=1 next cycle and overrun_sticky set.
  - The running epoch continues and the new epoch is dropped.
- A flag coinciding with DONE also counts as an overrun.
- Only one engine request is outstanding at any time.
- Best case per thread is 3 cycles (ARB, WAIT with eval, WAIT with response).
- rsp_valid and eval_valid are never asserted by reset paths.

Decomposition:
- Package sva_sched_pkg holds:
  - the sva_fsm_t enum and the sva_info_t packed struct, parameterised by TIMER_WIDTH;
  - the sched_state_t enum {IDLE, ARB, WAIT, DONE};
  - the default INFO_W.
- One sub-module, sva_rr_arbiter: combinational round-robin pick taking mask and rr_ptr, returning grant one-hot, grant id and a found flag.

Test Plan:
- Single queue, 2 threads, engine latency 1:
  - Flag, chk_en=0001, req_valid=1 with 2 threads, then req_done.
  - Expect 2 eval_valid pulses with eval_id=0, 2 rsp_valid[0] pulses, then epoch_done.
  - With succ flagged once, succ_cnt=1.
- Round-robin, engine latency 1:
  - chk_en=1111, every queue valid with 2 threads.
  - Expect eval_id sequence 0,1,2,3,0,1,2,3.
  - In the next epoch the sequence starts at 0 again, because rr_ptr=3.
- Empty epoch: chk_en=0000, flag at T -> epoch_done=1 exactly at T+2, no eval_valid.
- Overrun:
  - Engine latency 20; a second flag during WAIT.
  - Expect overrun pulse and overrun_sticky=1.
  - The first epoch completes with a single epoch_done.
- Saturation:
  - CNT_W=2, 5 fail responses.
  - Expect fail_cnt=3 and held.
- Reset mid-WAIT:
  - sys_rst=1 for one cycle, then a late eval_rsp_valid arrives.
  - Expect no rsp_valid, counters 0, state IDLE, epoch_busy=0.
